// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   start     ID/EX holds a valid M-extension op
//   funct3    M op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_data  operand A
//   rs2_data  operand B
//   flush     EX flush, aborts any op in flight
//   stall     hold PC, IF/ID and ID/EX while high
//   done      one-cycle result-valid pulse
//   result    M-op result, held until overwritten by the next completion
//   dbg_state current FSM state (IDLE=0, BUSY=1, FAST=2, DONE=3)
//
// Handshake: start is a level that is consumed only in IDLE while flush
// is low; stall rises combinationally in that same cycle so ID/EX holds
// the op, and done pulses for exactly one cycle when result is valid.
module ex_muldiv #(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [width-1:0] rs1_data,
   input  logic [width-1:0] rs2_data,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic [width-1:0] result,
   output logic [1:0]       dbg_state
);

   localparam int cw = $clog2(width) + 1;
   localparam logic [width-1:0] min_val = {1'b1, {(width-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, FAST, DONE} state_t;

   state_t           state, state_nxt;
   logic [cw-1:0]    cnt;
   logic [width-1:0] hi, lo, opb, result_q;
   logic [2:0]       op;
   logic             sign_x, sign_a, div_zero;

   // Operand decode, only meaningful while IDLE sees a start.
   logic             signed_a, signed_b, a_neg, b_neg;
   logic             is_zero, is_ovf, special;
   logic [width-1:0] abs_a, abs_b;

   always_comb begin
      signed_a = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]);
      signed_b = (funct3 == 3'b001) | (funct3[2] & ~funct3[0]);
      a_neg    = signed_a & rs1_data[width-1];
      b_neg    = signed_b & rs2_data[width-1];
      abs_a    = a_neg ? -rs1_data : rs1_data;
      abs_b    = b_neg ? -rs2_data : rs2_data;
      is_zero  = (rs2_data == '0);
      is_ovf   = ~funct3[0] & (rs1_data == min_val) & (rs2_data == '1);
      special  = funct3[2] & (is_zero | is_ovf);
   end

   // One radix-2 step. Multiply: hi:lo is the product register with the
   // multiplier shifting out of lo. Divide: hi is the partial remainder,
   // lo shifts the dividend out and the quotient bits in. The restoring
   // subtract fits in width bits because a successful difference is
   // always below the divisor.
   logic [width:0]     mul_sum, div_shift;
   logic               div_ge;
   logic [width-1:0]   step_hi, step_lo;
   logic [2*width-1:0] prod, prod_s;
   logic [width-1:0]   quo_s, rem_s, final_res, fast_res;

   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
      div_shift = {hi, lo[width-1]};
      div_ge    = (div_shift >= {1'b0, opb});
      if (op[2]) begin
         step_hi = div_ge ? (div_shift[width-1:0] - opb) : div_shift[width-1:0];
         step_lo = {lo[width-2:0], div_ge};
      end else begin
         step_hi = mul_sum[width:1];
         step_lo = {mul_sum[0], lo[width-1:1]};
      end
      prod   = {step_hi, step_lo};
      prod_s = sign_x ? -prod : prod;
      quo_s  = sign_x ? -step_lo : step_lo;
      rem_s  = sign_a ? -step_hi : step_hi;
      case (op)
         3'b000:                 final_res = prod_s[width-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod_s[2*width-1:width];
         3'b100, 3'b101:         final_res = quo_s;
         default:                final_res = rem_s;
      endcase
      // Special path keeps raw rs1 in lo: it is the remainder for x/0 and
      // the quotient (the minimum value) for signed overflow.
      if (div_zero) fast_res = op[1] ? lo : '1;
      else          fast_res = op[1] ? '0 : lo;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; flush wins over start and counter expiry.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (start) state_nxt = special ? FAST : BUSY;
            BUSY: if (cnt == cw'(1)) state_nxt = DONE;
            FAST: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Outputs.
   always_comb begin
      stall = 1'b0;
      done  = 1'b0;
      case (state)
         IDLE:       stall = start & ~flush & rst;
         BUSY, FAST: stall = ~flush;
         DONE:       done  = 1'b1;
         default:    stall = 1'b0;
      endcase
   end

   assign result    = result_q;
   assign dbg_state = state;

   // Datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         opb      <= '0;
         op       <= '0;
         sign_x   <= 1'b0;
         sign_a   <= 1'b0;
         div_zero <= 1'b0;
         result_q <= '0;
      end else if (!flush) begin
         case (state)
            IDLE: if (start) begin
               op       <= funct3;
               opb      <= abs_b;
               cnt      <= cw'(width);
               sign_x   <= a_neg ^ b_neg;
               sign_a   <= a_neg;
               div_zero <= is_zero;
               hi       <= '0;
               lo       <= special ? rs1_data : abs_a;
            end
            BUSY: begin
               hi  <= step_hi;
               lo  <= step_lo;
               cnt <= cnt - cw'(1);
               if (cnt == cw'(1)) result_q <= final_res;
            end
            FAST: result_q <= fast_res;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

   localparam logic [31:0] min_val = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        flush = 1'b0;
   logic        stall, done;
   logic [31:0] result;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_res = '0;

   ex_muldiv #(.width(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
      .stall(stall), .done(done), .result(result), .dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model: RISC-V M semantics with 64-bit arithmetic.
   function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      p = '0;
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == min_val && b == 32'hFFFF_FFFF) return min_val;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == min_val && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      return f3[2] && (b == 0 || (!f3[0] && a == min_val && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return min_val;
         3: return 32'($urandom_range(0, 200));
         default: return $urandom;
      endcase
   endfunction

   // Driver: issue one op, track latency, check stall/done/result.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input logic [31:0] exp);
      int lat;
      int lat_exp;
      bit got;
      logic [31:0] e;
      lat_exp = is_special(f3, a, b) ? 2 : 33;
      exp_q.push_back(exp);
      @(negedge clk);
      start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b;
      #1 chk("stall_on_start", {31'b0, stall}, 32'd1);
      lat = 0; got = 0;
      while (!got && lat < 50) begin
         @(posedge clk); #1;
         lat++;
         if (!hold && lat == 1) begin
            start = 1'b0; rs1_data = $urandom; rs2_data = $urandom;
         end
         if (done) got = 1;
         else if (stall !== 1'b1) chk("stall_busy", {31'b0, stall}, 32'd1);
      end
      chk("done_seen", {31'b0, got}, 32'd1);
      chk("latency", lat, lat_exp);
      chk("stall_at_done", {31'b0, stall}, 32'd0);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("result", result, e);
         last_res = e;
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      chk("single_done", {31'b0, done}, 32'd0);
      chk("result_hold", result, last_res);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      // reset
      #1;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;

      // directed
      run_op(3'b000, 32'h7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFEB);
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0000);
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE);
      run_op(3'b100, 32'hFFFF_FFF9, 32'h2, 0, 32'hFFFF_FFFD);
      run_op(3'b110, 32'hFFFF_FFF9, 32'h2, 0, 32'hFFFF_FFFF);
      run_op(3'b101, 32'd100, 32'd7, 0, 32'd14);
      run_op(3'b111, 32'd100, 32'd7, 0, 32'd2);
      run_op(3'b101, 32'h1234, 32'h0, 0, 32'hFFFF_FFFF);
      run_op(3'b110, 32'h1234, 32'h0, 0, 32'h1234);
      run_op(3'b100, min_val, 32'hFFFF_FFFF, 0, min_val);
      run_op(3'b110, min_val, 32'hFFFF_FFFF, 0, 32'h0);
      run_op(3'b000, 32'h7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB);
      run_op(3'b110, 32'h1234, 32'h0, 1, 32'h1234);

      // flush at BUSY cycle 10
      @(negedge clk);
      start = 1'b1; funct3 = 3'b000; rs1_data = 32'd5; rs2_data = 32'd9;
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1 chk("flush_stall", {31'b0, stall}, 32'd0);
      @(negedge clk); flush = 1'b0;
      chk("flush_no_done", {31'b0, done}, 32'd0);
      chk("flush_result", result, last_res);
      @(negedge clk);
      chk("flush_idle_stall", {31'b0, stall}, 32'd0);
      run_op(3'b000, 32'd5, 32'd9, 0, 32'd45);

      // random
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         run_op(f3, a, b, bit'($urandom_range(0, 1)), ref_op(f3, a, b));
      end

      // async reset mid-BUSY
      @(negedge clk);
      start = 1'b1; funct3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd3;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_stall", {31'b0, stall}, 32'd0);
      chk("arst_done", {31'b0, done}, 32'd0);
      chk("arst_result", result, 32'd0);
      @(negedge clk) rst = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (done !== 1'b0) chk("arst_no_done", {31'b0, done}, 32'd0);
      end
      last_res = 32'd0;
      run_op(3'b111, 32'd1000, 32'd3, 0, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

endmodule
